// File: rtl/pa_fmau_special_pipe_pkg.sv
// Shared constants and types for the FMAU special-result pipeline.
// The select and sign vectors are described both as bit indices and as packed structs.
package pa_fmau_special_pipe_pkg;

    localparam int SEL_SRC2  = 0;
    localparam int SEL_ZERO  = 1;
    localparam int SEL_INF   = 2;
    localparam int SEL_LFN   = 3;
    localparam int SEL_CNAN  = 4;
    localparam int SEL_QNAN0 = 5;
    localparam int SEL_QNAN1 = 6;
    localparam int SEL_QNAN2 = 7;

    localparam int SIGN_SRC2 = 0;
    localparam int SIGN_ZERO = 1;
    localparam int SIGN_INF  = 2;
    localparam int SIGN_LFN  = 3;

    localparam int FF_NX = 0;
    localparam int FF_UF = 1;
    localparam int FF_OF = 2;
    localparam int FF_DZ = 3;
    localparam int FF_NV = 4;

    localparam logic [31:0] SP_CNAN    = 32'h7FC0_0000;
    localparam logic [31:0] SP_INF_MAG = 32'h7F80_0000;
    localparam logic [31:0] SP_LFN_MAG = 32'h7F7F_FFFF;

    typedef struct packed {
        logic [2:0] qnan;
        logic       cnan;
        logic       lfn;
        logic       inf;
        logic       zero;
        logic       src2;
    } special_sel_t;

    typedef struct packed {
        logic lfn;
        logic inf;
        logic zero;
        logic src2;
    } special_sign_t;

    typedef enum logic [1:0] {SRC_0, SRC_1, SRC_2} src_pick_t;

    // qnan[0] wins if the one-hot guarantee is broken; src2 is also the non-NaN source.
    function automatic src_pick_t pick_src(input special_sel_t sel);
        if (sel.qnan[0])      return SRC_0;
        else if (sel.qnan[1]) return SRC_1;
        else                  return SRC_2;
    endfunction

endpackage

// File: rtl/pa_fmau_special_pipe_if.sv
// EX1-side inputs and EX3-side outputs of the special-result pipeline.
interface pa_fmau_special_pipe_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  ctrl_fmau_ex1_vld;
    logic                  ctrl_fmau_stall;
    logic                  ctrl_fmau_flush;
    logic                  ex1_special_cmplt;
    logic [7:0]            fmau_fpu_ex1_special_sel;
    logic [3:0]            fmau_fpu_ex1_special_sign;
    logic [4:0]            fmau_fpu_ex1_fflags;
    logic [DATA_WIDTH-1:0] dp_fmau_ex1_src0;
    logic [DATA_WIDTH-1:0] dp_fmau_ex1_src1;
    logic [DATA_WIDTH-1:0] dp_fmau_ex1_src2;
    logic                  fmau_ex2_special_vld;
    logic                  fmau_ex3_special_vld;
    logic [DATA_WIDTH-1:0] fmau_ex3_special_result;
    logic [4:0]            fmau_ex3_special_fflags;

    modport master (
        output ctrl_fmau_ex1_vld, ctrl_fmau_stall, ctrl_fmau_flush, ex1_special_cmplt,
               fmau_fpu_ex1_special_sel, fmau_fpu_ex1_special_sign, fmau_fpu_ex1_fflags,
               dp_fmau_ex1_src0, dp_fmau_ex1_src1, dp_fmau_ex1_src2,
        input  fmau_ex2_special_vld, fmau_ex3_special_vld,
               fmau_ex3_special_result, fmau_ex3_special_fflags
    );

    modport slave (
        input  ctrl_fmau_ex1_vld, ctrl_fmau_stall, ctrl_fmau_flush, ex1_special_cmplt,
               fmau_fpu_ex1_special_sel, fmau_fpu_ex1_special_sign, fmau_fpu_ex1_fflags,
               dp_fmau_ex1_src0, dp_fmau_ex1_src1, dp_fmau_ex1_src2,
        output fmau_ex2_special_vld, fmau_ex3_special_vld,
               fmau_ex3_special_result, fmau_ex3_special_fflags
    );
endinterface

// File: rtl/pa_fmau_special_result_mux.sv
// Combinational special-result priority mux; constants are built from the
// exponent/fraction widths so the same block serves other precisions.
module pa_fmau_special_result_mux
    import pa_fmau_special_pipe_pkg::*;
#(
    parameter int EXPN  = 8,
    parameter int FRAC  = 23,
    parameter int WIDTH = 1 + EXPN + FRAC
) (
    input  special_sel_t     sel_i,
    input  special_sign_t    sign_i,
    input  logic [WIDTH-1:0] src_i,
    output logic [WIDTH-1:0] result_o
);

    always_comb begin
        result_o = '0;
        if (|sel_i.qnan) begin
            result_o         = src_i;
            result_o[FRAC-1] = 1'b1;
        end else if (sel_i.cnan) begin
            result_o = {1'b0, {EXPN{1'b1}}, 1'b1, {(FRAC-1){1'b0}}};
        end else if (sel_i.inf) begin
            result_o = {sign_i.inf, {EXPN{1'b1}}, {FRAC{1'b0}}};
        end else if (sel_i.lfn) begin
            result_o = {sign_i.lfn, {(EXPN-1){1'b1}}, 1'b0, {FRAC{1'b1}}};
        end else if (sel_i.zero) begin
            result_o = {sign_i.zero, {(WIDTH-1){1'b0}}};
        end else if (sel_i.src2) begin
            result_o = {sign_i.src2, src_i[WIDTH-2:0]};
        end
    end

endmodule

// File: rtl/pa_fmau_special_pipe.sv
// EX2/EX3 carry of FMAU special-case results; forms the final special result and
// fflags in EX3, bypassing the multiply-add datapath.
module pa_fmau_special_pipe
    import pa_fmau_special_pipe_pkg::*;
#(
    parameter int SINGLE_EXPN = 8,
    parameter int SINGLE_FRAC = 23,
    parameter int DATA_WIDTH  = 1 + SINGLE_EXPN + SINGLE_FRAC
) (
    input  logic                    forever_cpuclk,
    input  logic                    cpurst_b,
    pa_fmau_special_pipe_if.slave   fmau
);

    localparam int STAGES = 2;

    // vld_pipe_q[1] is EX2, vld_pipe_q[2] is EX3.
    logic [STAGES:1]       vld_pipe_q, vld_pipe_d;
    logic                  adv, ex1_take;

    special_sel_t          ex2_sel_q,  ex3_sel_q;
    special_sign_t         ex2_sign_q, ex3_sign_q;
    logic [4:0]            ex2_ff_q,   ex3_ff_q;
    logic [DATA_WIDTH-1:0] ex2_src0_q, ex2_src1_q, ex2_src2_q;
    logic [DATA_WIDTH-1:0] ex2_src_pick, ex3_src_q;
    logic [DATA_WIDTH-1:0] ex3_result;

    assign adv      = !fmau.ctrl_fmau_stall;
    assign ex1_take = fmau.ctrl_fmau_ex1_vld && fmau.ex1_special_cmplt;

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        if (fmau.ctrl_fmau_flush) vld_pipe_d = '0;
        else if (adv)             vld_pipe_d = {vld_pipe_q[1], ex1_take};
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) vld_pipe_q <= '0;
        else           vld_pipe_q <= vld_pipe_d;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ex2_sel_q  <= '0;
            ex2_sign_q <= '0;
            ex2_ff_q   <= '0;
            ex2_src0_q <= '0;
            ex2_src1_q <= '0;
            ex2_src2_q <= '0;
        end else if (adv && ex1_take) begin
            ex2_sel_q  <= special_sel_t'(fmau.fmau_fpu_ex1_special_sel);
            ex2_sign_q <= special_sign_t'(fmau.fmau_fpu_ex1_special_sign);
            ex2_ff_q   <= fmau.fmau_fpu_ex1_fflags;
            ex2_src0_q <= fmau.dp_fmau_ex1_src0;
            ex2_src1_q <= fmau.dp_fmau_ex1_src1;
            ex2_src2_q <= fmau.dp_fmau_ex1_src2;
        end
    end

    // Narrow to the one operand EX3 can use so only a single source crosses into EX3.
    always_comb begin
        ex2_src_pick = ex2_src2_q;
        case (pick_src(ex2_sel_q))
            SRC_0:   ex2_src_pick = ex2_src0_q;
            SRC_1:   ex2_src_pick = ex2_src1_q;
            default: ex2_src_pick = ex2_src2_q;
        endcase
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            ex3_sel_q  <= '0;
            ex3_sign_q <= '0;
            ex3_ff_q   <= '0;
            ex3_src_q  <= '0;
        end else if (adv && vld_pipe_q[1]) begin
            ex3_sel_q  <= ex2_sel_q;
            ex3_sign_q <= ex2_sign_q;
            ex3_ff_q   <= ex2_ff_q;
            ex3_src_q  <= ex2_src_pick;
        end
    end

    pa_fmau_special_result_mux #(
        .EXPN  (SINGLE_EXPN),
        .FRAC  (SINGLE_FRAC),
        .WIDTH (DATA_WIDTH)
    ) u_result_mux (
        .sel_i    (ex3_sel_q),
        .sign_i   (ex3_sign_q),
        .src_i    (ex3_src_q),
        .result_o (ex3_result)
    );

    assign fmau.fmau_ex2_special_vld    = vld_pipe_q[1];
    assign fmau.fmau_ex3_special_vld    = vld_pipe_q[2];
    assign fmau.fmau_ex3_special_result = vld_pipe_q[2] ? ex3_result : '0;
    assign fmau.fmau_ex3_special_fflags = vld_pipe_q[2] ? ex3_ff_q : '0;

endmodule

// File: tb/tb_pa_fmau_special_pipe.sv
// Self-checking bench: vector table through a scoreboard, plus stall/flush/reset sequences.
module tb_pa_fmau_special_pipe;
    import pa_fmau_special_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pa_fmau_special_pipe_if #(.DATA_WIDTH(32)) bus();

    pa_fmau_special_pipe dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_n),
        .fmau           (bus)
    );

    typedef struct {
        logic        cmplt;
        logic [7:0]  sel;
        logic [3:0]  sign;
        logic [4:0]  ff;
        logic [31:0] s0, s1, s2;
        logic [31:0] res;
        logic [4:0]  eff;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  ff;
    } exp_t;

    exp_t sb[$];
    vec_t vt[14];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ctrl_fmau_ex1_vld         = 1'b0;
        bus.ex1_special_cmplt         = 1'b0;
        bus.ctrl_fmau_stall           = 1'b0;
        bus.ctrl_fmau_flush           = 1'b0;
        bus.fmau_fpu_ex1_special_sel  = '0;
        bus.fmau_fpu_ex1_special_sign = '0;
        bus.fmau_fpu_ex1_fflags       = '0;
        bus.dp_fmau_ex1_src0          = '0;
        bus.dp_fmau_ex1_src1          = '0;
        bus.dp_fmau_ex1_src2          = '0;
    endtask

    // Expected output is queued only when the pipe will actually accept the instruction.
    task automatic drive(input vec_t v);
        exp_t e;
        bus.ctrl_fmau_ex1_vld         = 1'b1;
        bus.ex1_special_cmplt         = v.cmplt;
        bus.fmau_fpu_ex1_special_sel  = v.sel;
        bus.fmau_fpu_ex1_special_sign = v.sign;
        bus.fmau_fpu_ex1_fflags       = v.ff;
        bus.dp_fmau_ex1_src0          = v.s0;
        bus.dp_fmau_ex1_src1          = v.s1;
        bus.dp_fmau_ex1_src2          = v.s2;
        if (v.cmplt && !bus.ctrl_fmau_stall && !bus.ctrl_fmau_flush) begin
            e.res = v.res;
            e.ff  = v.eff;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        chk("drain_empty", sb.size(), 0);
    endtask

    // An EX3 result stays at the queue head while stalled, so a stall also checks stability.
    always @(negedge clk) begin
        if (bus.fmau_ex3_special_vld) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_ex3_vld: got result %h with empty scoreboard",
                         bus.fmau_ex3_special_result);
            end else begin
                chk("ex3_result", bus.fmau_ex3_special_result, sb[0].res);
                chk("ex3_fflags", {27'b0, bus.fmau_ex3_special_fflags}, {27'b0, sb[0].ff});
                if (!bus.ctrl_fmau_stall) void'(sb.pop_front());
            end
        end else begin
            chk("idle_result", bus.fmau_ex3_special_result, 32'h0);
            chk("idle_fflags", {27'b0, bus.fmau_ex3_special_fflags}, 32'h0);
        end
    end

    initial begin
        //          cmplt sel    sign   ff      src0          src1          src2          result        fflags
        vt[0]  = '{1'b1, 8'h10, 4'h0, 5'h10, 32'h0,        32'h0,        32'h0,        SP_CNAN,      5'h10};
        vt[1]  = '{1'b1, 8'h40, 4'h0, 5'h10, 32'h0,        32'hFF812345, 32'h0,        32'hFFC12345, 5'h10};
        vt[2]  = '{1'b1, 8'h04, 4'h4, 5'h08, 32'h0,        32'h0,        32'h0,        32'hFF800000, 5'h08};
        vt[3]  = '{1'b1, 8'h08, 4'h0, 5'h05, 32'h0,        32'h0,        32'h0,        SP_LFN_MAG,   5'h05};
        vt[4]  = '{1'b1, 8'h02, 4'h2, 5'h00, 32'h0,        32'h0,        32'h0,        32'h80000000, 5'h00};
        vt[5]  = '{1'b1, 8'h01, 4'h1, 5'h00, 32'h0,        32'h0,        32'h3F800000, 32'hBF800000, 5'h00};
        vt[6]  = '{1'b1, 8'h01, 4'h0, 5'h01, 32'h0,        32'h0,        32'hC0000000, 32'h40000000, 5'h01};
        vt[7]  = '{1'b1, 8'h20, 4'h0, 5'h10, 32'h7F800001, 32'h0,        32'h0,        32'h7FC00001, 5'h10};
        vt[8]  = '{1'b1, 8'h80, 4'hF, 5'h10, 32'h0,        32'h0,        32'h00000001, 32'h00400001, 5'h10};
        vt[9]  = '{1'b1, 8'h00, 4'hF, 5'h01, 32'hAAAAAAAA, 32'h55555555, 32'hAAAAAAAA, 32'h0,        5'h01};
        vt[10] = '{1'b1, 8'h60, 4'h0, 5'h10, 32'h12345678, 32'h87654321, 32'h0,        32'h12745678, 5'h10};
        vt[11] = '{1'b1, 8'h14, 4'h4, 5'h10, 32'h0,        32'h0,        32'h0,        SP_CNAN,      5'h10};
        vt[12] = '{1'b1, 8'h0C, 4'h8, 5'h04, 32'h0,        32'h0,        32'h0,        SP_INF_MAG,   5'h04};
        vt[13] = '{1'b0, 8'h10, 4'h0, 5'h10, 32'h0,        32'h0,        32'h0,        32'h0,        5'h00};

        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex2_vld", bus.fmau_ex2_special_vld, 0);
        chk("rst_ex3_vld", bus.fmau_ex3_special_vld, 0);
        chk("rst_result",  bus.fmau_ex3_special_result, 0);
        chk("rst_fflags",  bus.fmau_ex3_special_fflags, 0);
        rst_n = 1'b1;
        tick();

        // Two-cycle latency with a single cnan instruction.
        drive(vt[0]);
        tick();
        idle();
        @(negedge clk);
        chk("lat_ex2_vld", bus.fmau_ex2_special_vld, 1);
        chk("lat_ex3_early", bus.fmau_ex3_special_vld, 0);
        tick();
        @(negedge clk);
        chk("lat_ex3_vld", bus.fmau_ex3_special_vld, 1);
        tick();
        @(negedge clk);
        chk("lat_ex3_gone", bus.fmau_ex3_special_vld, 0);
        tick();

        // Back-to-back table.
        foreach (vt[i]) begin
            drive(vt[i]);
            tick();
        end
        idle();
        drain();

        // Stall while in EX2, then while in EX3; a competing EX1 instruction is offered but refused.
        drive(vt[2]);
        tick();
        bus.ctrl_fmau_stall = 1'b1;
        drive(vt[4]);
        repeat (3) begin
            @(negedge clk);
            chk("stall_ex2_hold", bus.fmau_ex2_special_vld, 1);
            chk("stall_ex3_empty", bus.fmau_ex3_special_vld, 0);
            tick();
        end
        idle();
        tick();
        bus.ctrl_fmau_stall = 1'b1;
        drive(vt[5]);
        repeat (2) tick();
        idle();
        @(negedge clk);
        chk("stall_release_vld", bus.fmau_ex3_special_vld, 1);
        tick();
        @(negedge clk);
        chk("stall_after_vld", bus.fmau_ex3_special_vld, 0);
        tick();

        // Flush together with stall empties both stages; next instruction has normal latency.
        drive(vt[0]);
        tick();
        drive(vt[2]);
        tick();
        idle();
        bus.ctrl_fmau_stall = 1'b1;
        bus.ctrl_fmau_flush = 1'b1;
        @(negedge clk);
        chk("flush_pre_ex2", bus.fmau_ex2_special_vld, 1);
        chk("flush_pre_ex3", bus.fmau_ex3_special_vld, 1);
        tick();
        idle();
        sb.delete();
        @(negedge clk);
        chk("flush_ex2_clr", bus.fmau_ex2_special_vld, 0);
        chk("flush_ex3_clr", bus.fmau_ex3_special_vld, 0);
        tick();
        drive(vt[4]);
        tick();
        idle();
        @(negedge clk);
        chk("post_flush_ex2", bus.fmau_ex2_special_vld, 1);
        chk("post_flush_ex3_early", bus.fmau_ex3_special_vld, 0);
        tick();
        @(negedge clk);
        chk("post_flush_ex3", bus.fmau_ex3_special_vld, 1);
        chk("post_flush_result", bus.fmau_ex3_special_result, 32'h80000000);
        tick();

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        drive(vt[0]);
        tick();
        idle();
        tick();
        #2;
        chk("arst_pre_vld", bus.fmau_ex3_special_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_ex3_vld", bus.fmau_ex3_special_vld, 0);
        chk("arst_ex2_vld", bus.fmau_ex2_special_vld, 0);
        chk("arst_result",  bus.fmau_ex3_special_result, 0);
        chk("arst_fflags",  bus.fmau_ex3_special_fflags, 0);
        sb.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        drive(vt[3]);
        tick();
        idle();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
